cmp_stream_packer: RTL and testbench

//  Downstream neighbour of the Compressor. Accepts variable-length compressed chunks
//  (1..32 valid bytes per 256-bit word) and packs them back-to-back into dense 256-bit

---
 rtl/cmp_stream_packer.sv | 97 +++++++++
 tb/tb_cmp_stream_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_stream_packer.sv
// Packs variable-length byte chunks back-to-back into dense DATA_W-bit beats.
// A frame end flushes the remainder as a short final beat tagged out_last.
module cmp_stream_packer #(
  parameter int DATA_W = 256,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_bytes,
  output logic              out_last
);

  localparam int NB     = DATA_W / 8;
  localparam int FILL_W = LEN_W + 1;
  localparam logic [FILL_W-1:0] NB_F = FILL_W'(NB);

  typedef enum logic {ACCUM, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] buf_q, buf_d;
  logic [FILL_W-1:0]   fill_q, fill_d;

  logic                in_fire, out_fire;
  logic [FILL_W-1:0]   pop, len, base;
  logic [DATA_W-1:0]   mask;
  logic [2*DATA_W-1:0] shifted, app;

  // Handshake and beat descriptors depend only on registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bytes = '0;
    out_last  = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready  = (fill_q <= NB_F);
        out_valid = (fill_q >= NB_F);
        if (out_valid) out_bytes = LEN_W'(NB);
      end
      FLUSH: begin
        out_valid = 1'b1;
        if (fill_q > NB_F) begin
          out_bytes = LEN_W'(NB);
        end else begin
          out_bytes = fill_q[LEN_W-1:0];
          out_last  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_data = buf_q[DATA_W-1:0];

  // Pop first, then append the masked chunk right after the surviving bytes.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    pop      = '0;
    if (out_fire) pop = (fill_q > NB_F) ? NB_F : fill_q;
    len = (FILL_W'(in_len) > NB_F) ? NB_F : FILL_W'(in_len);
    if (!in_fire) len = '0;
    mask    = ~({DATA_W{1'b1}} << {len, 3'b000});
    base    = fill_q - pop;
    shifted = buf_q >> {pop, 3'b000};
    app     = {{DATA_W{1'b0}}, in_data & mask} << {base, 3'b000};
    buf_d   = shifted | app;
    fill_d  = base + len;
    state_d = state_q;
    case (state_q)
      ACCUM:   if (in_fire && in_last) state_d = FLUSH;
      FLUSH:   if (out_fire && out_last) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      buf_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_cmp_stream_packer.sv
// Self-checking bench for cmp_stream_packer: vector table, corner-case
// sequences and a randomized run against a byte-queue reference model.
module tb_cmp_stream_packer;

  localparam int NB = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_last;
  logic [255:0] in_data;
  logic [5:0]   in_len;
  logic         out_valid, out_ready, out_last;
  logic [255:0] out_data;
  logic [5:0]   out_bytes;

  int checks = 0;
  int fails  = 0;

  cmp_stream_packer #(.DATA_W(256), .LEN_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_len(in_len), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [5:0]   len;
    logic         last;
    logic         ordy;
    logic         expValid;
    logic         expReady;
    logic [5:0]   expBytes;
    logic         expLast;
    logic [255:0] expData;
  } vec_t;

  vec_t vecs[9];

  // Word whose byte i holds start+i for i<n, zero elsewhere.
  function automatic logic [255:0] mkSeq(int start, int n);
    logic [255:0] w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = 8'(start + i);
    return w;
  endfunction

  task automatic checkOutput(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkStatus(string name, logic v, logic r, logic [5:0] b, logic l);
    checkOutput({name, "_status"}, 256'({out_valid, in_ready, out_bytes, out_last}),
                256'({v, r, b, l}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic v, logic [5:0] len, logic last,
                               logic [255:0] d, logic ordy);
    in_valid  = v;
    in_len    = len;
    in_last   = last;
    in_data   = d;
    out_ready = ordy;
    tick();
  endtask

  // Reference model: pending bytes in arrival order plus a flushing flag.
  byte unsigned q[$];
  bit           flushing;

  task automatic randomRun(int cycles);
    logic [255:0] d, expData;
    logic [5:0]   len, expBytes;
    logic         v, last, ordy, expValid, expReady, expLast;
    int           take, popN;
    for (int c = 0; c < cycles; c++) begin
      v    = ($urandom_range(0, 9) < 7);
      len  = 6'($urandom_range(0, 36) > 34 ? $urandom_range(33, 63) : $urandom_range(0, 34));
      last = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      expReady = !flushing && (q.size() <= NB);
      expValid = flushing || (q.size() >= NB);
      expLast  = flushing && (q.size() <= NB);
      expBytes = !expValid ? 6'd0 : (expLast ? 6'(q.size()) : 6'(NB));
      expData  = '0;
      for (int i = 0; i < q.size() && i < NB; i++) expData[8*i +: 8] = q[i];
      checkStatus("rand", expValid, expReady, expBytes, expLast);
      checkOutput("rand_data", out_data, expData);
      popN = (expValid && ordy) ? ((q.size() < NB) ? q.size() : NB) : 0;
      for (int i = 0; i < popN; i++) void'(q.pop_front());
      if (expValid && ordy && expLast) flushing = 0;
      if (v && expReady) begin
        take = (len > 6'(NB)) ? NB : int'(len);
        for (int i = 0; i < take; i++) q.push_back(d[8*i +: 8]);
        if (last) flushing = 1;
      end
      applyStimulus(v, len, last, d, ordy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [255:0] pat, held;
    int           acc;
    bit           stable;

    reset = 1'b1; in_valid = 0; in_len = 0; in_last = 0; in_data = '0; out_ready = 0;
    tick(); tick();
    reset = 1'b0;
    checkStatus("reset_init", 1'b0, 1'b1, 6'd0, 1'b0);
    checkOutput("reset_init_data", out_data, '0);

    // Vector table: eight 4-byte chunks form one beat, upper bytes masked.
    pat = {8{32'hFEDCBA98}};
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{1'b1, 6'd4, 1'b0, 1'b1, (k == 7), 1'b1, (k == 7) ? 6'd32 : 6'd0, 1'b0,
                  pat & ~({256{1'b1}} << (32 * (k + 1)))};
    end
    vecs[8] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, '0};
    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k].vld, vecs[k].len, vecs[k].last, pat, vecs[k].ordy);
      checkStatus($sformatf("pack%0d", k), vecs[k].expValid, vecs[k].expReady,
                  vecs[k].expBytes, vecs[k].expLast);
      checkOutput($sformatf("pack%0d_data", k), out_data, vecs[k].expData);
    end

    // Reset mid-frame discards partial data.
    applyStimulus(1, 6'd20, 0, mkSeq(8'h60, 32), 0);
    reset = 1'b1;
    #2;
    checkStatus("reset_mid", 1'b0, 1'b1, 6'd0, 1'b0);
    checkOutput("reset_mid_data", out_data, '0);
    tick();
    reset = 1'b0;
    applyStimulus(1, 6'd32, 0, mkSeq(8'h40, 32), 0);
    checkStatus("post_reset", 1'b1, 1'b1, 6'd32, 1'b0);
    checkOutput("post_reset_data", out_data, mkSeq(8'h40, 32));
    applyStimulus(0, 6'd0, 0, '0, 1);

    // Flush with a partial final beat.
    applyStimulus(1, 6'd20, 0, mkSeq(8'h01, 32), 0);
    applyStimulus(1, 6'd20, 1, mkSeq(8'h21, 32), 0);
    checkStatus("flush_b0", 1'b1, 1'b0, 6'd32, 1'b0);
    checkOutput("flush_b0_data", out_data, mkSeq(8'h01, 20) | (mkSeq(8'h21, 12) << 160));
    applyStimulus(0, 6'd0, 0, '0, 1);
    checkStatus("flush_b1", 1'b1, 1'b0, 6'd8, 1'b1);
    checkOutput("flush_b1_data", out_data, mkSeq(8'h2D, 8));
    applyStimulus(0, 6'd0, 0, '0, 1);
    checkStatus("flush_done", 1'b0, 1'b1, 6'd0, 1'b0);

    // Backpressure: nine chunks fit before in_ready drops at fill 36.
    acc = 0;
    stable = 1;
    held = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 9) held = out_data;
      if (k > 9 && out_data !== held) stable = 0;
      if (in_ready) begin
        applyStimulus(1, 6'd4, 0, mkSeq(1 + 4 * acc, 4), 0);
        acc++;
      end else begin
        applyStimulus(1, 6'd4, 0, mkSeq(1 + 4 * acc, 4), 0);
      end
    end
    checkOutput("bp_accepted", 256'(acc), 256'(9));
    checkStatus("bp_stall", 1'b1, 1'b0, 6'd32, 1'b0);
    checkOutput("bp_stable", 256'(stable), 256'(1));
    checkOutput("bp_data", out_data, mkSeq(1, 32));
    applyStimulus(0, 6'd0, 0, '0, 1);
    checkStatus("bp_drain", 1'b0, 1'b1, 6'd0, 1'b0);
    checkOutput("bp_drain_data", out_data, mkSeq(33, 4));
    applyStimulus(1, 6'd0, 1, '1, 0);
    checkStatus("bp_tail", 1'b1, 1'b0, 6'd4, 1'b1);
    checkOutput("bp_tail_data", out_data, mkSeq(33, 4));
    applyStimulus(0, 6'd0, 0, '0, 1);
    checkStatus("bp_done", 1'b0, 1'b1, 6'd0, 1'b0);

    // Concurrent pop and full-width append at fill 32.
    applyStimulus(1, 6'd32, 0, mkSeq(8'h80, 32), 0);
    applyStimulus(1, 6'd32, 0, mkSeq(8'hA0, 32), 1);
    checkStatus("conc", 1'b1, 1'b1, 6'd32, 1'b0);
    checkOutput("conc_data", out_data, mkSeq(8'hA0, 32));
    applyStimulus(0, 6'd0, 0, '0, 1);
    checkStatus("conc_done", 1'b0, 1'b1, 6'd0, 1'b0);

    // Empty frame end produces a zero-byte last beat.
    applyStimulus(1, 6'd0, 1, '1, 0);
    checkStatus("empty", 1'b1, 1'b0, 6'd0, 1'b1);
    checkOutput("empty_data", out_data, '0);
    applyStimulus(0, 6'd0, 0, '0, 1);
    checkStatus("empty_done", 1'b0, 1'b1, 6'd0, 1'b0);

    q.delete();
    flushing = 0;
    randomRun(600);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
